// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core front end.
//   - XLEN / ILEN : address and instruction widths
//   - NOP_INSTR   : encoding loaded into IF/ID for a bubble
//   - fetch_state_e : fetch FSM states (IDLE, REQ, HOLD, DISCARD)
//   - pc_plus4()  : sequential PC step, 32-bit modulo
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   freeze_i               : hold all contents (highest priority)
//   flush_i                : load a bubble (NOP, PCplus4 kept, valid=0)
//   load_i                 : load instr_i / pcplus4_i with valid=1
//   instr_i, pcplus4_i     : data to load
//   instr_o, pcplus4_o, valid_o : registered contents
// Priority: freeze > flush > load > hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [ILEN-1:0] instr_q,   instr_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q,   valid_d;

  // Next-state selection for the pipeline register.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (freeze_i) begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
    end else if (flush_i) begin
      // Bubble keeps PCplus4 so downstream sees a stable address.
      instr_d   = NOP_INSTR;
      pcplus4_d = pcplus4_q;
      valid_d   = 1'b0;
    end else if (load_i) begin
      instr_d   = instr_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end else begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
    end
  end

  // Pipeline register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, drives the instruction
// memory request handshake, buffers one response while IF/ID is frozen and
// drops wrong-path responses after an ID-stage redirect.
// Parameters:
//   RESET_PC      : PC after reset (word aligned)
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   pc_freeze     : no new request may start
//   IF_ID_freeze  : IF/ID holds; also masks branch_taken
//   branch_taken, branch_target : ID-stage redirect
//   imem_req, imem_addr         : request (stable until imem_ready)
//   imem_ready, imem_rdata      : response
//   IF_ID_Instr, IF_ID_PCplus4, IF_ID_valid : IF/ID register
//   stall_cycles  : fetch-wait counter
// Build option: define FETCH_PERF_EN to implement the saturating wait-cycle
// counter; otherwise stall_cycles is tied to zero.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_freeze,
  input  logic            IF_ID_freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] IF_ID_Instr,
  output logic [XLEN-1:0] IF_ID_PCplus4,
  output logic            IF_ID_valid,
  output logic [31:0]     stall_cycles
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [ILEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pcp4_q, buf_pcp4_d;
  logic            imem_req_q;

  logic            redirect_s;
  logic            go_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic            ifid_load_s;
  logic            ifid_flush_s;
  logic [ILEN-1:0] ifid_instr_s;
  logic [XLEN-1:0] ifid_pcp4_s;

  // A branch seen while IF/ID is frozen belongs to a stalled ID stage.
  assign redirect_s = branch_taken && !IF_ID_freeze;
  assign pc_plus4_s = pc_plus4(pc_q);

  // Fetch FSM next state, PC, request address, hold buffer and IF/ID controls.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    buf_instr_d  = buf_instr_q;
    buf_pcp4_d   = buf_pcp4_q;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_instr_s = imem_rdata;
    ifid_pcp4_s  = pc_plus4_s;
    go_s         = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect_s) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_q;
        end
        go_s = 1'b1;
      end
      REQ: begin
        if (imem_ready) begin
          if (redirect_s) begin
            pc_d         = branch_target;
            ifid_flush_s = 1'b1;
            go_s         = 1'b1;
          end else if (IF_ID_freeze) begin
            buf_instr_d = imem_rdata;
            buf_pcp4_d  = pc_plus4_s;
            pc_d        = pc_plus4_s;
            state_d     = HOLD;
          end else begin
            ifid_load_s = 1'b1;
            pc_d        = pc_plus4_s;
            go_s        = 1'b1;
          end
        end else begin
          if (redirect_s) begin
            // Request must stay stable, so its data is marked dead instead.
            pc_d         = branch_target;
            ifid_flush_s = 1'b1;
            state_d      = DISCARD;
          end else begin
            state_d = REQ;
          end
        end
      end
      DISCARD: begin
        if (redirect_s) begin
          pc_d         = branch_target;
          ifid_flush_s = 1'b1;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ready) begin
          go_s = 1'b1;
        end else begin
          state_d = DISCARD;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          pc_d         = branch_target;
          ifid_flush_s = 1'b1;
          go_s         = 1'b1;
        end else if (!IF_ID_freeze) begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = buf_instr_q;
          ifid_pcp4_s  = buf_pcp4_q;
          go_s         = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // "Go": start the next request unless the hazard unit holds the PC.
    // Entering REQ always captures the PC value being written this edge.
    if (go_s) begin
      if (pc_freeze) begin
        state_d = IDLE;
      end else begin
        state_d    = REQ;
        req_addr_d = pc_d;
      end
    end else begin
      req_addr_d = req_addr_q;
    end
  end

  // FSM, PC, request address, hold buffer and registered request valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pcp4_q  <= 32'h0000_0000;
      imem_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pcp4_q  <= buf_pcp4_d;
      imem_req_q  <= (state_d == REQ) || (state_d == DISCARD);
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = req_addr_q;

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze_i  (IF_ID_freeze),
    .flush_i   (ifid_flush_s),
    .load_i    (ifid_load_s),
    .instr_i   (ifid_instr_s),
    .pcplus4_i (ifid_pcp4_s),
    .instr_o   (IF_ID_Instr),
    .pcplus4_o (IF_ID_PCplus4),
    .valid_o   (IF_ID_valid)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles spent waiting on the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
    end else if (imem_req_q && !imem_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'h0000_0001;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_freeze;
  logic        IF_ID_freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;

  logic        req_a, valid_a, req_w, valid_w;
  logic [31:0] addr_a, rdata_a, instr_a, pcp4_a, stall_a;
  logic [31:0] addr_w, rdata_w, instr_w, pcp4_w, stall_w;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr_q[$];

`ifdef FETCH_PERF_EN
  localparam logic [31:0] EXP_STALL5 = 32'd5;
`else
  localparam logic [31:0] EXP_STALL5 = 32'd0;
`endif

  always #5 clk = ~clk;

  // Memory content model: each word is a fixed scramble of its address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign rdata_a = instr_of(addr_a);
  assign rdata_w = instr_of(addr_w);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_freeze(pc_freeze), .IF_ID_freeze(IF_ID_freeze),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready), .imem_rdata(rdata_a),
    .IF_ID_Instr(instr_a), .IF_ID_PCplus4(pcp4_a), .IF_ID_valid(valid_a),
    .stall_cycles(stall_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc_freeze(pc_freeze), .IF_ID_freeze(IF_ID_freeze),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ready(imem_ready), .imem_rdata(rdata_w),
    .IF_ID_Instr(instr_w), .IF_ID_PCplus4(pcp4_w), .IF_ID_valid(valid_w),
    .stall_cycles(stall_w)
  );

  // Scoreboard: each completed handshake must match the next expected address.
  always @(negedge clk) begin : mon_blk
    logic [31:0] e;
    if (rst_n === 1'b1 && req_a === 1'b1 && imem_ready === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL handshake_addr: got %h, no request expected", addr_a);
      end else begin
        e = exp_addr_q.pop_front();
        if (addr_a !== e) begin
          errors++;
          $display("FAIL handshake_addr: got %h want %h", addr_a, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_freeze = 1'b0; IF_ID_freeze = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b1;
    step(); step();
    checks++;
    if ({req_a, addr_a, instr_a, pcp4_a, valid_a, stall_a} !==
        {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got req=%b addr=%h ins=%h p4=%h v=%b st=%0d want all 0",
               req_a, addr_a, instr_a, pcp4_a, valid_a, stall_a);
    end
    checks++;
    if ({req_w, addr_w} !== {1'b0, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL reset_wrap_addr: got req=%b addr=%h want 0/fffffffc", req_w, addr_w);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_steady_fetch();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    step();
    checks++;
    if ({req_a, addr_a, valid_a} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL first_request: got req=%b addr=%h v=%b want 1/0/0", req_a, addr_a, valid_a);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({req_a, instr_a, pcp4_a, valid_a} !==
          {1'b1, instr_of(32'(4 * k)), 32'(4 * k + 4), 1'b1}) begin
        errors++;
        $display("FAIL steady_ifid k=%0d: got req=%b %h/%h/%b want 1 %h/%h/1",
                 k, req_a, instr_a, pcp4_a, valid_a, instr_of(32'(4 * k)), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_load_use();
    exp_addr_q.push_back(32'h8);
    pc_freeze = 1'b1; IF_ID_freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({req_a, instr_a, pcp4_a, valid_a} !== {1'b0, instr_of(32'h4), 32'h8, 1'b1}) begin
        errors++;
        $display("FAIL loaduse_hold k=%0d: got req=%b %h/%h/%b want 0 %h/00000008/1",
                 k, req_a, instr_a, pcp4_a, valid_a, instr_of(32'h4));
      end
    end
    pc_freeze = 1'b0; IF_ID_freeze = 1'b0;
    exp_addr_q.push_back(32'hC);
    step();
    checks++;
    if ({req_a, addr_a, instr_a, pcp4_a, valid_a} !== {1'b1, 32'hC, instr_of(32'h8), 32'hC, 1'b1}) begin
      errors++;
      $display("FAIL loaduse_release: got req=%b addr=%h %h/%h/%b want 1 c %h/c/1",
               req_a, addr_a, instr_a, pcp4_a, valid_a, instr_of(32'h8));
    end
    step();
    checks++;
    if ({addr_a, instr_a, pcp4_a, valid_a} !== {32'h10, instr_of(32'hC), 32'h10, 1'b1}) begin
      errors++;
      $display("FAIL loaduse_next: got addr=%h %h/%h/%b want 10 %h/10/1",
               addr_a, instr_a, pcp4_a, valid_a, instr_of(32'hC));
    end
  endtask

  task automatic test_redirect_wait();
    exp_addr_q.push_back(32'h10);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    for (int k = 0; k < 3; k++) begin
      step();
      branch_taken = 1'b0;
      checks++;
      if ({req_a, addr_a, instr_a, pcp4_a, valid_a} !== {1'b1, 32'h10, 32'h0, 32'h10, 1'b0}) begin
        errors++;
        $display("FAIL redirect_wait k=%0d: got req=%b addr=%h %h/%h/%b want 1 10 0/10/0",
                 k, req_a, addr_a, instr_a, pcp4_a, valid_a);
      end
    end
    imem_ready = 1'b1;
    exp_addr_q.push_back(32'h100);
    step();
    checks++;
    if ({req_a, addr_a, instr_a, pcp4_a, valid_a} !== {1'b1, 32'h100, 32'h0, 32'h10, 1'b0}) begin
      errors++;
      $display("FAIL redirect_target: got req=%b addr=%h %h/%h/%b want 1 100 0/10/0",
               req_a, addr_a, instr_a, pcp4_a, valid_a);
    end
    step();
    checks++;
    if ({addr_a, instr_a, pcp4_a, valid_a} !== {32'h104, instr_of(32'h100), 32'h104, 1'b1}) begin
      errors++;
      $display("FAIL redirect_land: got addr=%h %h/%h/%b want 104 %h/104/1",
               addr_a, instr_a, pcp4_a, valid_a, instr_of(32'h100));
    end
  endtask

  task automatic test_frozen_redirect();
    exp_addr_q.push_back(32'h104);
    IF_ID_freeze = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    checks++;
    if ({req_a, instr_a, pcp4_a, valid_a} !== {1'b0, instr_of(32'h100), 32'h104, 1'b1}) begin
      errors++;
      $display("FAIL frozen_hold: got req=%b %h/%h/%b want 0 %h/104/1",
               req_a, instr_a, pcp4_a, valid_a, instr_of(32'h100));
    end
    IF_ID_freeze = 1'b0; branch_taken = 1'b0;
    exp_addr_q.push_back(32'h108);
    step();
    checks++;
    if ({req_a, addr_a, instr_a, pcp4_a, valid_a} !== {1'b1, 32'h108, instr_of(32'h104), 32'h108, 1'b1}) begin
      errors++;
      $display("FAIL frozen_no_redirect: got req=%b addr=%h %h/%h/%b want 1 108 %h/108/1",
               req_a, addr_a, instr_a, pcp4_a, valid_a, instr_of(32'h104));
    end
    pc_freeze = 1'b1;
    step();
    checks++;
    if ({req_a, instr_a, pcp4_a, valid_a} !== {1'b0, instr_of(32'h108), 32'h10C, 1'b1}) begin
      errors++;
      $display("FAIL pc_freeze_idle: got req=%b %h/%h/%b want 0 %h/10c/1",
               req_a, instr_a, pcp4_a, valid_a, instr_of(32'h108));
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; pc_freeze = 1'b0; imem_ready = 1'b1;
    step();
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_requests: got %0d pending want 0", exp_addr_q.size());
    end
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0);
    step();
    checks++;
    if ({req_w, addr_w} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", req_w, addr_w);
    end
    step();
    imem_ready = 1'b0;
    checks++;
    if ({addr_w, instr_w, pcp4_w, valid_w} !== {32'h0, instr_of(32'hFFFF_FFFC), 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_second: got addr=%h %h/%h/%b want 0 %h/0/1",
               addr_w, instr_w, pcp4_w, valid_w, instr_of(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_counter();
    // Reset lands while the address-4 request is still outstanding.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_a, instr_a, pcp4_a, valid_a, stall_a} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_request: got req=%b %h/%h/%b st=%0d want all 0",
               req_a, instr_a, pcp4_a, valid_a, stall_a);
    end
    step(); step();
    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if ({req_a, stall_a} !== {1'b1, EXP_STALL5}) begin
      errors++;
      $display("FAIL stall_count: got req=%b cnt=%0d want 1/%0d", req_a, stall_a, EXP_STALL5);
    end
    imem_ready = 1'b1; pc_freeze = 1'b1;
    step();
    checks++;
    if ({req_a, stall_a, instr_a, pcp4_a, valid_a} !== {1'b0, EXP_STALL5, instr_of(32'h0), 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL stall_after: got req=%b cnt=%0d %h/%h/%b want 0 %0d %h/4/1",
               req_a, stall_a, instr_a, pcp4_a, valid_a, EXP_STALL5, instr_of(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_steady_fetch();
    test_load_use();
    test_redirect_wait();
    test_frozen_redirect();
    test_wrap();
    test_counter();
    step();
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL missing_requests: got %0d pending want 0", exp_addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
